// File: rtl/dram_responder_if.sv
// Memory-stage <-> data-array bus for dram_responder.
//
// Handshake: a request is offered by holding mem_ce_i = 1 with its attributes.
// The responder accepts it in any cycle where it is idle and not in reset.
// A store completes in its accept cycle. A load raises stall_req_o in its
// accept cycle, which plays the role of "not ready". The requester keeps the
// load presented through the following cycle, in which mem_data_o and err_o
// are valid. err_o pulses in the cycle after any misaligned access is accepted.
interface dram_responder_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [2:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stall_req_o;
  logic        err_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, stall_req_o, err_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, stall_req_o, err_o
  );
endinterface

// File: rtl/dram_responder.sv
// Single-port word-organised data array serving a pipeline memory stage.
// Stores commit in one cycle; loads take two cycles (accept with stall, then
// registered data). Sub-word loads return the full aligned word.
module dram_responder #(
  parameter int ADDR_W    = 12,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  dram_responder_if.slave bus,
  output logic [0:0]  state_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RD   = 1'b1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  // Simulation start-up value of the array; reset never touches it.
  localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0 : 32'hxxxx_xxxx;

  logic [31:0] mem_q [DEPTH] = '{default: INIT_WORD};

  logic [0:0]        state_q, state_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic [3:0]        byte_en;
  logic [31:0]       wr_data;
  logic              accept;
  logic              load_acc;
  logic              store_en;

  assign word_idx = bus.mem_addr_i[ADDR_W+1:2];

  // Decode size/alignment into a misaligned flag, lane enables and lane data.
  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    wr_data    = bus.mem_data_i;
    case (bus.mem_sel_i)
      3'b000: begin
        byte_en = 4'b0001 << bus.mem_addr_i[1:0];
        wr_data = {4{bus.mem_data_i[7:0]}};
      end
      3'b001: begin
        misaligned = bus.mem_addr_i[0];
        byte_en    = bus.mem_addr_i[1] ? 4'b1100 : 4'b0011;
        wr_data    = {2{bus.mem_data_i[15:0]}};
      end
      3'b010: begin
        misaligned = (bus.mem_addr_i[1:0] != 2'b00);
        byte_en    = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
    if (misaligned) byte_en = 4'b0000;
  end

  // Requests are only taken while idle and out of reset.
  always_comb begin
    accept   = !rst && (state_q == IDLE) && bus.mem_ce_i;
    load_acc = accept && !bus.mem_we_i;
    store_en = accept && bus.mem_we_i && !misaligned;
  end

  // Next state, registered load data and error pulse.
  always_comb begin
    state_d    = state_q;
    mem_data_d = mem_data_q;
    err_d      = 1'b0;
    if (rst) begin
      state_d    = IDLE;
      mem_data_d = 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          err_d = accept && misaligned;
          if (load_acc) begin
            state_d    = RD;
            mem_data_d = misaligned ? 32'h0 : mem_q[word_idx];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_data_q <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_data_q <= mem_data_d;
      err_q      <= err_d;
    end
  end

  // Array write port: only enabled byte lanes of an aligned store are written.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int l = 0; l < 4; l++) begin
        if (byte_en[l]) mem_q[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

  assign bus.stall_req_o = load_acc;
  assign bus.mem_data_o  = mem_data_q;
  assign bus.err_o       = err_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder: load results go through an expected queue
// consumed by a monitor; control outputs are checked inline by the drivers.
module tb_dram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:0]  state;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];      // {err, data} of each accepted load
  logic        rd_pending = 1'b0;

  dram_responder_if bus();

  dram_responder #(.ADDR_W(12), .INIT_ZERO(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: the cycle after a stall (accepted load) carries the load result.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rd_pending) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ld_data", bus.mem_data_o, e[31:0]);
        check("ld_err", {31'd0, bus.err_o}, {31'd0, e[32]});
      end
    end
    rd_pending = (bus.stall_req_o === 1'b1);
  end

  task automatic idle_bus();
    bus.mem_ce_i   = 1'b0;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = 32'h0;
    bus.mem_sel_i  = 3'b010;
    bus.mem_data_i = 32'h0;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.mem_ce_i   = 1'b1;
    bus.mem_we_i   = we;
    bus.mem_addr_i = a;
    bus.mem_sel_i  = s;
    bus.mem_data_i = d;
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d, input logic exp_err);
    @(posedge clk); #1;
    drive(1'b1, a, s, d);
    @(negedge clk);
    check("st_stall", {31'd0, bus.stall_req_o}, 32'd0);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check("st_err", {31'd0, bus.err_o}, {31'd0, exp_err});
    check("st_state", {31'd0, state}, 32'd0);
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] s, input logic [31:0] exp_d, input logic exp_err);
    @(posedge clk); #1;
    drive(1'b0, a, s, 32'h0);
    @(negedge clk);
    check("ld_stall_accept", {31'd0, bus.stall_req_o}, 32'd1);
    exp_q.push_back({exp_err, exp_d});
    @(posedge clk); #1;       // RD cycle; load stays presented
    @(negedge clk);
    check("ld_stall_rd", {31'd0, bus.stall_req_o}, 32'd0);
    check("ld_state_rd", {31'd0, state}, 32'd1);
    @(posedge clk); #1;
    idle_bus();
  endtask

  initial begin
    // Reset with a load presented: no stall, outputs cleared
    idle_bus();
    drive(1'b0, 32'h0, 3'b010, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("rst_data", bus.mem_data_o, 32'h0);
    check("rst_err", {31'd0, bus.err_o}, 32'd0);
    check("rst_state", {31'd0, state}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_bus();

    // Basic word store/load
    store(32'h100, 3'b010, 32'h1234_5678, 1'b0);
    load (32'h100, 3'b010, 32'h1234_5678, 1'b0);

    // Sub-word merges
    store(32'h200, 3'b010, 32'hFFFF_FFFF, 1'b0);
    store(32'h201, 3'b000, 32'h0000_00AB, 1'b0);
    store(32'h202, 3'b001, 32'hCDEF_CDEF, 1'b0);
    load (32'h200, 3'b010, 32'hCDEF_ABFF, 1'b0);

    // Misaligned and invalid-size stores write nothing and flag an error
    store(32'h300, 3'b010, 32'h1111_1111, 1'b0);
    store(32'h301, 3'b001, 32'h2222_2222, 1'b1);
    store(32'h302, 3'b010, 32'h3333_3333, 1'b1);
    store(32'h300, 3'b111, 32'h4444_4444, 1'b1);
    load (32'h300, 3'b010, 32'h1111_1111, 1'b0);

    // Misaligned load returns zero with error in the data cycle
    load (32'h102, 3'b010, 32'h0, 1'b1);

    // Address wrap at 2^12 words
    store(32'h4000, 3'b010, 32'hA5A5_A5A5, 1'b0);
    load (32'h0000, 3'b010, 32'hA5A5_A5A5, 1'b0);

    // Back-to-back stores, then read both; byte load returns the whole word
    @(posedge clk); #1;
    drive(1'b1, 32'h400, 3'b010, 32'hAAAA_0001);
    @(negedge clk);
    check("b2b_stall0", {31'd0, bus.stall_req_o}, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 32'h404, 3'b010, 32'hBBBB_0002);
    @(negedge clk);
    check("b2b_stall1", {31'd0, bus.stall_req_o}, 32'd0);
    check("b2b_err", {31'd0, bus.err_o}, 32'd0);
    @(posedge clk); #1;
    idle_bus();
    load (32'h403, 3'b000, 32'hAAAA_0001, 1'b0);
    load (32'h404, 3'b010, 32'hBBBB_0002, 1'b0);

    // Output holds across stores and idle cycles
    store(32'h500, 3'b010, 32'h5555_5555, 1'b0);
    check("hold_after_st", bus.mem_data_o, 32'hBBBB_0002);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("hold_idle", bus.mem_data_o, 32'hBBBB_0002);
    check("idle_stall", {31'd0, bus.stall_req_o}, 32'd0);

    // Reset during RD aborts the load; a store under reset is dropped
    @(posedge clk); #1;
    drive(1'b0, 32'h200, 3'b010, 32'h0);
    @(negedge clk);
    check("abort_stall_accept", {31'd0, bus.stall_req_o}, 32'd1);
    exp_q.push_back({1'b0, 32'hCDEF_ABFF});
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, 32'h200, 3'b010, 32'h0);
    @(negedge clk);
    check("abort_stall_rst", {31'd0, bus.stall_req_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_state", {31'd0, state}, 32'd0);
    check("abort_data", bus.mem_data_o, 32'h0);
    check("abort_stall", {31'd0, bus.stall_req_o}, 32'd0);
    check("abort_err", {31'd0, bus.err_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_bus();
    load (32'h200, 3'b010, 32'hCDEF_ABFF, 1'b0);

    // Drain and report
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
